// File: rtl/inhibit_controller_if.sv
// ---------------------------------------------------------------------------
// inhibit_controller_if
// Bundles the control/result signals of one column's lateral-inhibition
// sequencer so the controller and its neighbours connect with one port.
//
//   start         sequencer in   one-cycle pulse that opens a gamma window
//   spikes_in     sequencer in   N active-low spike lines
//   inhibit       sequencer out  drives the downstream inhibitor
//   clear_lines   sequencer out  asks upstream to return the lines high
//   busy          sequencer out  window open (RUN or CLEAR)
//   done          sequencer out  one-cycle pulse at end of CLEAR
//   winner_valid  sequencer out  a winner was captured this/last window
//   winner_idx    sequencer out  index of the first line to fire
//   winner_time   sequencer out  arrival time of that line
//   spike_count   sequencer out  distinct lines fired this/last window
//
// The slave modport belongs to the controller; the master modport belongs
// to whoever drives start/spikes_in and consumes the results.
// ---------------------------------------------------------------------------
interface inhibit_controller_if #(
    parameter int N   = 16,
    parameter int T_W = 6
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(N + 1);

    logic             start;
    logic [N-1:0]     spikes_in;
    logic             inhibit;
    logic             clear_lines;
    logic             busy;
    logic             done;
    logic             winner_valid;
    logic [IDX_W-1:0] winner_idx;
    logic [T_W-1:0]   winner_time;
    logic [CNT_W-1:0] spike_count;

    modport master (
        output start,
        output spikes_in,
        input  inhibit,
        input  clear_lines,
        input  busy,
        input  done,
        input  winner_valid,
        input  winner_idx,
        input  winner_time,
        input  spike_count
    );

    modport slave (
        input  start,
        input  spikes_in,
        output inhibit,
        output clear_lines,
        output busy,
        output done,
        output winner_valid,
        output winner_idx,
        output winner_time,
        output spike_count
    );
endinterface

// File: rtl/inhibit_controller.sv
// ---------------------------------------------------------------------------
// inhibit_controller
// Sequencer for one column's lateral-inhibition stage in the race-logic
// datapath. Opens a gamma window on start, timestamps active-low spike
// arrivals, raises inhibit once K distinct lines have fired, reports the
// earliest line and its arrival time, then holds the column in CLEAR until
// every line is back high.
//
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of inhibit_controller_if (start, spikes_in in;
//          inhibit, clear_lines, busy, done, winner_*, spike_count out)
//
// State table
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | window closed, results of last window held, waiting for start
//   S_RUN   | sampling spikes, GAMMA_LEN samples at t = 0..GAMMA_LEN-1
//   S_CLEAR | inhibit forced high, waiting for all lines to return high
// ---------------------------------------------------------------------------
module inhibit_controller #(
    parameter int N         = 16,
    parameter int K         = 1,
    parameter int GAMMA_LEN = 40,
    parameter int T_W       = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    inhibit_controller_if.slave  bus
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(N + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;

    // The window timer counts down to a terminal count of zero; the arrival
    // time reported to the outside is recovered as T_LAST - remaining.
    localparam logic [T_W-1:0]   T_LAST = T_W'(GAMMA_LEN - 1);
    localparam logic [CNT_W-1:0] K_THR  = CNT_W'(K);

    logic [1:0]       state_q,   state_d;
    logic [T_W-1:0]   rem_q,     rem_d;
    logic [N-1:0]     seen_q,    seen_d;
    logic [CNT_W-1:0] count_q,   count_d;
    logic             wvalid_q,  wvalid_d;
    logic [IDX_W-1:0] widx_q,    widx_d;
    logic [T_W-1:0]   wtime_q,   wtime_d;
    logic             inhibit_q, inhibit_d;
    logic             clear_q,   clear_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;

    logic [N-1:0]     fresh;
    logic [CNT_W-1:0] fresh_cnt;
    logic [IDX_W-1:0] first_idx;
    logic [CNT_W-1:0] count_sum;
    logic [T_W-1:0]   t_now;

    // Lines that are low this sample and have not fired earlier in the
    // window. Scanning from the top down leaves the lowest set index in
    // first_idx, which gives the tie-break for simultaneous arrivals.
    always_comb begin
        fresh     = ~bus.spikes_in & ~seen_q;
        fresh_cnt = '0;
        first_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            fresh_cnt = fresh_cnt + CNT_W'(fresh[i]);
            if (fresh[i]) begin
                first_idx = IDX_W'(i);
            end
        end
    end

    // seen_q is sticky, so the sum can never exceed N and needs no clamp.
    assign count_sum = count_q + fresh_cnt;
    assign t_now     = T_LAST - rem_q;

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        seen_d    = seen_q;
        count_d   = count_q;
        wvalid_d  = wvalid_q;
        widx_d    = widx_q;
        wtime_d   = wtime_q;
        inhibit_d = inhibit_q;
        clear_d   = clear_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                inhibit_d = 1'b0;
                clear_d   = 1'b0;
                busy_d    = 1'b0;
                if (bus.start) begin
                    state_d  = S_RUN;
                    rem_d    = T_LAST;
                    seen_d   = '0;
                    count_d  = '0;
                    wvalid_d = 1'b0;
                    widx_d   = '0;
                    wtime_d  = '0;
                    busy_d   = 1'b1;
                end
            end

            S_RUN: begin
                seen_d  = seen_q | fresh;
                count_d = count_sum;
                // Late spikes still count, but the first capture is final.
                if (!wvalid_q && (fresh != '0)) begin
                    wvalid_d = 1'b1;
                    widx_d   = first_idx;
                    wtime_d  = t_now;
                end
                if (count_sum >= K_THR) begin
                    inhibit_d = 1'b1;
                end
                if (rem_q == '0) begin
                    state_d   = S_CLEAR;
                    inhibit_d = 1'b1;
                    clear_d   = 1'b1;
                end else begin
                    rem_d = rem_q - T_W'(1);
                end
            end

            S_CLEAR: begin
                // No timeout: the column stays parked until upstream has
                // released every line.
                if (&bus.spikes_in) begin
                    state_d   = S_IDLE;
                    inhibit_d = 1'b0;
                    clear_d   = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end
            end

            default: begin
                state_d   = S_IDLE;
                inhibit_d = 1'b0;
                clear_d   = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rem_q     <= '0;
            seen_q    <= '0;
            count_q   <= '0;
            wvalid_q  <= 1'b0;
            widx_q    <= '0;
            wtime_q   <= '0;
            inhibit_q <= 1'b0;
            clear_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            seen_q    <= seen_d;
            count_q   <= count_d;
            wvalid_q  <= wvalid_d;
            widx_q    <= widx_d;
            wtime_q   <= wtime_d;
            inhibit_q <= inhibit_d;
            clear_q   <= clear_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.inhibit      = inhibit_q;
    assign bus.clear_lines  = clear_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.winner_valid = wvalid_q;
    assign bus.winner_idx   = widx_q;
    assign bus.winner_time  = wtime_q;
    assign bus.spike_count  = count_q;
endmodule

// File: tb/tb_inhibit_controller.sv
module tb_inhibit_controller;
    localparam int N  = 16;
    localparam int GL = 40;
    localparam int TW = 6;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] spikes = '1;

    int n_checks = 0;
    int n_pass   = 0;

    inhibit_controller_if #(.N(N), .T_W(TW)) bus1 ();
    inhibit_controller_if #(.N(N), .T_W(TW)) bus3 ();

    assign bus1.start     = start;
    assign bus1.spikes_in = spikes;
    assign bus3.start     = start;
    assign bus3.spikes_in = spikes;

    inhibit_controller #(.N(N), .K(1), .GAMMA_LEN(GL), .T_W(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    inhibit_controller #(.N(N), .K(3), .GAMMA_LEN(GL), .T_W(TW)) dut_k3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------- model: first-low time per line ----------------
    // Inputs as seen at each rising edge.
    logic         smp_rst   = 1'b0;
    logic         smp_start = 1'b0;
    logic [N-1:0] smp_spk   = '1;

    always @(posedge clk) begin
        smp_rst   <= rst_n;
        smp_start <= start;
        smp_spk   <= spikes;
    end

    int m_phase;          // 0 idle, 1 run, 2 clear
    int m_s;              // samples taken in current window
    int m_done;
    int first_low [N];    // sample index of first low level, -1 if never

    task automatic model_reset();
        m_phase = 0;
        m_s     = 0;
        m_done  = 0;
        for (int i = 0; i < N; i++) first_low[i] = -1;
    endtask

    task automatic model_step();
        m_done = 0;
        if (m_phase == 0) begin
            if (smp_start) begin
                m_phase = 1;
                m_s     = 0;
                for (int i = 0; i < N; i++) first_low[i] = -1;
            end
        end else if (m_phase == 1) begin
            for (int i = 0; i < N; i++)
                if (!smp_spk[i] && first_low[i] < 0) first_low[i] = m_s;
            if (m_s == GL - 1) m_phase = 2;
            m_s++;
        end else begin
            if (&smp_spk) begin
                m_phase = 0;
                m_done  = 1;
            end
        end
    endtask

    task automatic compare_all();
        int cnt, widx, wt, wv, best;
        cnt = 0; widx = 0; wt = 0; wv = 0; best = 1000000;
        for (int i = 0; i < N; i++) begin
            if (first_low[i] >= 0) begin
                cnt++;
                if (first_low[i] < best) begin
                    best = first_low[i];
                    widx = i;
                    wt   = first_low[i];
                    wv   = 1;
                end
            end
        end
        chk("k1_busy",    int'(bus1.busy),         int'(m_phase != 0));
        chk("k1_clear",   int'(bus1.clear_lines),  int'(m_phase == 2));
        chk("k1_done",    int'(bus1.done),         m_done);
        chk("k1_inhibit", int'(bus1.inhibit),      int'(m_phase == 2 || (m_phase == 1 && cnt >= 1)));
        chk("k1_wvalid",  int'(bus1.winner_valid), wv);
        chk("k1_widx",    int'(bus1.winner_idx),   widx);
        chk("k1_wtime",   int'(bus1.winner_time),  wt);
        chk("k1_count",   int'(bus1.spike_count),  cnt);
        chk("k3_busy",    int'(bus3.busy),         int'(m_phase != 0));
        chk("k3_done",    int'(bus3.done),         m_done);
        chk("k3_inhibit", int'(bus3.inhibit),      int'(m_phase == 2 || (m_phase == 1 && cnt >= 3)));
        chk("k3_widx",    int'(bus3.winner_idx),   widx);
        chk("k3_count",   int'(bus3.spike_count),  cnt);
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else if (smp_rst) model_step();
            #1;
            compare_all();
        end
    end

    // ---------------- stimulus ----------------
    // Line i is low for stimulus index k in [fall1,rise1) or [fall2,rise2).
    // Index k is the value sampled at edge start+1+k (k < GL is RUN sample t=k).
    int fall1 [N];
    int rise1 [N];
    int fall2 [N];
    int rise2 [N];

    task automatic clear_sched();
        for (int i = 0; i < N; i++) begin
            fall1[i] = -1; rise1[i] = -1; fall2[i] = -1; rise2[i] = -1;
        end
    endtask

    task automatic drive_pattern(input int k);
        for (int i = 0; i < N; i++) begin
            spikes[i] = !((fall1[i] >= 0 && k >= fall1[i] && k < rise1[i]) ||
                          (fall2[i] >= 0 && k >= fall2[i] && k < rise2[i]));
        end
    endtask

    // done_k / inh*_k are edge counts after the start edge at which the
    // output is first seen high; -1 if never.
    task automatic run_window(input int extra_start_k, input int abort_k, input int budget,
                              output int done_k, output int inh1_k, output int inh3_k);
        int k;
        done_k = -1; inh1_k = -1; inh3_k = -1;
        @(negedge clk);
        start  = 1'b1;
        spikes = '1;
        @(posedge clk);
        k = 0;
        while (1) begin
            @(negedge clk);
            if (bus1.inhibit && inh1_k < 0) inh1_k = k;
            if (bus3.inhibit && inh3_k < 0) inh3_k = k;
            if (k == abort_k) begin
                #2;
                rst_n  = 1'b0;
                start  = 1'b0;
                spikes = '1;
                #1;
                chk("rst_inhibit", int'(bus1.inhibit),      0);
                chk("rst_busy",    int'(bus1.busy),         0);
                chk("rst_clear",   int'(bus1.clear_lines),  0);
                chk("rst_wvalid",  int'(bus1.winner_valid), 0);
                chk("rst_widx",    int'(bus1.winner_idx),   0);
                chk("rst_count",   int'(bus1.spike_count),  0);
                chk("rst_k3_busy", int'(bus3.busy),         0);
                break;
            end
            if (bus1.done) begin
                done_k = k;
                start  = 1'b0;
                spikes = '1;
                break;
            end
            if (k >= budget) begin
                n_checks++;
                $display("FAIL window_timeout: got no done after %0d cycles, expected done", k);
                start  = 1'b0;
                spikes = '1;
                break;
            end
            start = (k == extra_start_k);
            drive_pattern(k);
            @(posedge clk);
            k++;
        end
    endtask

    task automatic check_results(input string tag, input int wv, input int idx, input int tm, input int cnt);
        chk({tag, "_wvalid"}, int'(bus1.winner_valid), wv);
        chk({tag, "_widx"},   int'(bus1.winner_idx),   idx);
        chk({tag, "_wtime"},  int'(bus1.winner_time),  tm);
        chk({tag, "_count"},  int'(bus1.spike_count),  cnt);
        chk({tag, "_k3_count"}, int'(bus3.spike_count), cnt);
    endtask

    initial begin
        int dk, i1, i3;
        clear_sched();
        repeat (3) @(negedge clk);
        chk("reset_busy",    int'(bus1.busy),         0);
        chk("reset_inhibit", int'(bus1.inhibit),      0);
        chk("reset_count",   int'(bus1.spike_count),  0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic window: line 1 at t=5, line 13 at t=7.
        clear_sched();
        fall1[1] = 5;  rise1[1] = 39;
        fall1[13] = 7; rise1[13] = 39;
        run_window(-1, -1, 120, dk, i1, i3);
        chk("basic_done_lat", dk, 41);
        chk("basic_inh1_lat", i1, 6);
        chk("basic_inh3_lat", i3, 40);
        check_results("basic", 1, 1, 5, 2);

        // Tie-break: lines 12 and 4 together at t=3.
        clear_sched();
        fall1[12] = 3; rise1[12] = 30;
        fall1[4]  = 3; rise1[4]  = 30;
        run_window(-1, -1, 120, dk, i1, i3);
        chk("tie_done_lat", dk, 41);
        chk("tie_inh1_lat", i1, 4);
        chk("tie_inh3_lat", i3, 40);
        check_results("tie", 1, 4, 3, 2);

        // K=3: lines 5, 9, 2 at t=2, 6, 10; line 5 re-falls at t=8 and must
        // not be recounted.
        clear_sched();
        fall1[5] = 2;  rise1[5] = 4;
        fall2[5] = 8;  rise2[5] = 35;
        fall1[9] = 6;  rise1[9] = 35;
        fall1[2] = 10; rise1[2] = 35;
        run_window(-1, -1, 120, dk, i1, i3);
        chk("k3_done_lat", dk, 41);
        chk("k3_inh1_lat", i1, 3);
        chk("k3_inh3_lat", i3, 11);
        check_results("k3", 1, 5, 2, 3);

        // CLEAR hold: line 0 already low at t=0, line 7 low until 10 cycles
        // into CLEAR; a start during CLEAR must be dropped.
        clear_sched();
        fall1[0] = 0;  rise1[0] = 20;
        fall1[7] = 15; rise1[7] = 50;
        run_window(45, -1, 120, dk, i1, i3);
        chk("hold_done_lat", dk, 51);
        chk("hold_inh1_lat", i1, 1);
        chk("hold_inh3_lat", i3, 40);
        check_results("hold", 1, 0, 0, 2);

        // No spikes: results cleared by the new start.
        clear_sched();
        run_window(-1, -1, 120, dk, i1, i3);
        chk("none_done_lat", dk, 41);
        chk("none_inh1_lat", i1, 40);
        chk("none_inh3_lat", i3, 40);
        check_results("none", 0, 0, 0, 0);

        // Reset mid-RUN with inhibit high.
        clear_sched();
        fall1[0] = 2; rise1[0] = 60;
        run_window(-1, 21, 120, dk, i1, i3);
        chk("abort_inh1_lat", i1, 3);
        chk("abort_no_done", dk, -1);
        repeat (3) begin
            @(negedge clk);
            chk("abort_done_low", int'(bus1.done), 0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_idle_busy", int'(bus1.busy), 0);

        // Normal window after the reset.
        clear_sched();
        fall1[1] = 5;  rise1[1] = 39;
        fall1[13] = 7; rise1[13] = 39;
        run_window(-1, -1, 120, dk, i1, i3);
        chk("post_done_lat", dk, 41);
        chk("post_inh1_lat", i1, 6);
        check_results("post", 1, 1, 5, 2);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
